alu_share_sched: RTL and testbench

Arbitrated scheduler that shares one combinational add/multiply/shift ALU between two requesters. Each requester owns a private 8-bit accumulator context held inside this block. The scheduler accepts one operation at a time over a valid/ready handshake, executes it against the winner's accumulator, and returns the new accumulator value on a response channel tagged with the requester ID. It sits between two command sources (for example, a switch-driven front panel and a test sequencer) and the lab's accumulator datapath.

---
 rtl/alu_sched_pkg.sv | 21 ++
 rtl/alu_core.sv | 32 +++
 rtl/alu_share_sched.sv | 118 +++++++++++
 tb/tb_alu_share_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and default widths for the shared-ALU scheduler.
// Imported by alu_core and alu_share_sched.
package alu_sched_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int RES_W_DEF  = 8;

    typedef enum logic [1:0] {
        F_ADD  = 2'd0,
        F_MUL  = 2'd1,
        F_SHL  = 2'd2,
        F_HOLD = 2'd3
    } func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational add/multiply/shift ALU shared by both accumulator contexts.
// HOLD passes B through; the caller substitutes the full accumulator.
module alu_core
    import alu_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  func_t             func_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [RES_W-1:0]  result_o
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;

    assign a_ext = RES_W'(a_i);
    assign b_ext = RES_W'(b_i);

    always_comb begin
        result_o = '0;
        unique case (func_i)
            F_ADD:   result_o = a_ext + b_ext;
            F_MUL:   result_o = a_ext * b_ext;
            // Shifting the whole accumulator width or more clears it.
            F_SHL:   result_o = (32'(a_i) >= RES_W) ? '0 : (b_ext << a_i);
            default: result_o = b_ext;
        endcase
    end

endmodule

// File: rtl/alu_share_sched.sv
// Two-requester scheduler sharing one ALU, each with a private accumulator.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_share_sched
    import alu_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic                Clock,
    input  logic                Reset_b,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [3:0]          req_func,
    input  logic [2*DATA_W-1:0] req_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [RES_W-1:0]    rsp_result,
    output logic                busy
);

    state_t            state_q, state_d;
    logic              id_q;
    func_t             func_q;
    logic [DATA_W-1:0] data_q;
    logic [RES_W-1:0]  acc_q [2];
    logic              rsp_id_q;
    logic [RES_W-1:0]  rsp_result_q;

    logic              grant;
    logic              accept;
    logic [1:0]        sel_func;
    logic [DATA_W-1:0] sel_data;
    logic [RES_W-1:0]  alu_res;
    logic [RES_W-1:0]  new_acc;

`ifdef ALU_SCHED_FIXED_PRIO_EN
    assign grant = ~req_valid[0];
`else
    logic last_q;

    // On a tie the requester not served last time wins.
    assign grant = (&req_valid) ? ~last_q : ~req_valid[0];

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant;
        end
    end
`endif

    assign accept   = (state_q == IDLE) && (|req_valid);
    assign sel_func = grant ? req_func[3:2] : req_func[1:0];
    assign sel_data = grant ? req_data[2*DATA_W-1:DATA_W]
                            : req_data[DATA_W-1:0];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    alu_core #(
        .DATA_W (DATA_W),
        .RES_W  (RES_W)
    ) u_alu (
        .func_i   (func_q),
        .a_i      (data_q),
        .b_i      (acc_q[id_q][DATA_W-1:0]),
        .result_o (alu_res)
    );

    assign new_acc = (func_q == F_HOLD) ? acc_q[id_q] : alu_res;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)    state_d = EXEC;
            EXEC:                   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q      <= IDLE;
            id_q         <= 1'b0;
            func_q       <= F_ADD;
            data_q       <= '0;
            acc_q[0]     <= '0;
            acc_q[1]     <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q   <= grant;
                func_q <= func_t'(sel_func);
                data_q <= sel_data;
            end
            if (state_q == EXEC) begin
                acc_q[id_q]  <= new_acc;
                rsp_id_q     <= id_q;
                rsp_result_q <= new_acc;
            end
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench for alu_share_sched: directed plan plus random traffic.
// Expected responses come from an arithmetic model of the two accumulators.
module tb_alu_share_sched;

    logic       Clock = 1'b0;
    logic       Reset_b = 1'b0;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [3:0] req_func = '0;
    logic [7:0] req_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_id;
    logic [7:0] rsp_result;
    logic       busy;

    alu_share_sched dut (
        .Clock      (Clock),
        .Reset_b    (Reset_b),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_func   (req_func),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int done_cnt = 0;
    int stall = 0;
    bit force_ready = 1'b1;

    int m_acc [2];
    int m_last = 1;
    bit pend_v [2];
    int pend_f [2];
    int pend_d [2];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_alu(input int f, input int a, input int acc);
        int b;
        b = acc % 16;
        case (f)
            0: return (a + b) % 256;
            1: return (a * b) % 256;
            2: return (a >= 8) ? 0 : ((b << a) % 256);
            default: return acc;
        endcase
    endfunction

    function automatic int exp_grant(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
            return 0;
`else
            return (m_last == 0) ? 1 : 0;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    task automatic drive_reqs();
        req_valid = {pend_v[1], pend_v[0]};
        req_func  = {2'(pend_f[1]), 2'(pend_f[0])};
        req_data  = {4'(pend_d[1]), 4'(pend_d[0])};
    endtask

    task automatic set_req(input int i, input int f, input int d);
        pend_v[i] = 1'b1;
        pend_f[i] = f;
        pend_d[i] = d;
    endtask

    task automatic do_op(output int busy_n);
        int g, res, old, cyc;
        busy_n = 0;
        @(negedge Clock);
        #1 drive_reqs();
        #1;
        check("idle_busy", int'(busy), 0);
        if (!pend_v[0] && !pend_v[1]) begin
            check("ready_none", int'(req_ready), 0);
            return;
        end
        g = exp_grant(pend_v[0], pend_v[1]);
        check("req_ready", int'(req_ready), 1 << g);
        res = ref_alu(pend_f[g], pend_d[g], m_acc[g]);
        m_acc[g] = res;
        m_last = g;
        exp_q.push_back(g * 256 + res);
        pend_v[g] = 1'b0;
        old = done_cnt;
        cyc = 0;
        @(posedge Clock);
        forever begin
            @(negedge Clock);
            #1 drive_reqs();
            #1;
            if (busy) busy_n++;
            check("ready_busy", int'(req_ready), 0);
            if (done_cnt != old) break;
            cyc++;
            if (cyc > 40) begin
                check("rsp_timeout", cyc, 0);
                break;
            end
        end
    endtask

    task automatic drain();
        int bn;
        for (int k = 0; k < 4; k++) begin
            if (pend_v[0] || pend_v[1]) do_op(bn);
        end
    endtask

    // Monitor: pops on each presented response and rechecks while stalled.
    int cur;
    bit have = 1'b0;
    always @(negedge Clock) begin
        if (!Reset_b) begin
            have = 1'b0;
        end else if (rsp_valid) begin
            if (!have) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got id %0d result %0d expected none",
                             rsp_id, rsp_result);
                    cur = int'(rsp_id) * 256 + int'(rsp_result);
                end else begin
                    cur = exp_q.pop_front();
                end
                have = 1'b1;
            end
            check("rsp_id", int'(rsp_id), cur / 256);
            check("rsp_result", int'(rsp_result), cur % 256);
            if (stall > 0) begin
                rsp_ready = 1'b0;
                stall--;
            end else if (force_ready) begin
                rsp_ready = 1'b1;
            end else begin
                rsp_ready = ($urandom % 4) != 0;
            end
            if (rsp_ready) begin
                have = 1'b0;
                done_cnt++;
            end
        end else begin
            rsp_ready = 1'($urandom % 2);
        end
    end

    initial begin
        int bn;
        m_acc[0] = 0;
        m_acc[1] = 0;
        repeat (3) @(negedge Clock);
        #1;
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_rsp_id", int'(rsp_id), 0);
        check("rst_rsp_result", int'(rsp_result), 0);
        Reset_b = 1'b1;

        set_req(0, 0, 5);
        do_op(bn);
        check("busy_cycles", bn, 2);
        set_req(0, 1, 3);  do_op(bn);
        set_req(0, 2, 4);  do_op(bn);
        set_req(0, 0, 1);  do_op(bn);
        set_req(1, 3, 0);  do_op(bn);
        set_req(1, 0, 9);  do_op(bn);
        set_req(1, 2, 4);  do_op(bn);
        set_req(1, 3, 0);  do_op(bn);
        set_req(1, 2, 12); do_op(bn);
        set_req(1, 0, 9);  do_op(bn);
        set_req(1, 2, 9);  do_op(bn);
        set_req(1, 3, 0);  do_op(bn);

        for (int k = 0; k < 6; k++) begin
            if (!pend_v[0]) set_req(0, 0, 1);
            if (!pend_v[1]) set_req(1, 0, 2);
            do_op(bn);
        end
        drain();

        stall = 5;
        set_req(0, 1, 2);
        set_req(1, 0, 3);
        do_op(bn);
        drain();

        set_req(0, 0, 7);
        @(negedge Clock);
        #1 drive_reqs();
        #1 check("rstx_ready", int'(req_ready), 1);
        pend_v[0] = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        #1 Reset_b = 1'b0;
        drive_reqs();
        #1;
        check("rstx_rsp_valid", int'(rsp_valid), 0);
        check("rstx_busy", int'(busy), 0);
        check("rstx_req_ready", int'(req_ready), 0);
        m_acc[0] = 0;
        m_acc[1] = 0;
        m_last = 1;
        @(negedge Clock);
        #1 Reset_b = 1'b1;
        set_req(0, 3, 0); do_op(bn);
        set_req(1, 3, 0); do_op(bn);

        force_ready = 1'b0;
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend_v[i] && ($urandom % 3) != 0) begin
                    set_req(i, int'($urandom % 4), int'($urandom % 16));
                end
            end
            do_op(bn);
        end
        drain();

        repeat (4) @(negedge Clock);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
